udp_writer: RTL and testbench
=============================

UDP_WRITER -- requirements
Module: udp_writer

Interface
REQ-001 Parameter CAPACITY, default 1, SHALL set the payload length in bytes (legal range 1..1472).
REQ-002 Parameter TIMEOUT, default 65535, SHALL set the max cycles spent waiting for grant in REQ (0 = never time out).
REQ-003 clk  input  1  SHALL be the clock; all logic is rising-edge.
REQ-004 rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 send  input  1  SHALL be a one-cycle request to transmit i_data.
REQ-006 i_data  input  CAPACITY*8  SHALL be the payload; byte k is bits [(CAPACITY-k)*8-1 -: 8], so the MSB byte is byte 0.
REQ-007 tx_req  output  1  SHALL request the UDP stack for a transmit slot.
REQ-008 tx_ready  input  1  SHALL be the stack grant for tx_req.
REQ-009 tx_data_req  input  1  SHALL be the stack per-byte ready.
REQ-010 o_valid  output  1  SHALL qualify o_data.
REQ-011 o_data  output  8  SHALL carry the current payload byte.
REQ-012 o_last  output  1  SHALL flag the final payload byte.
REQ-013 o_len  output  16  SHALL be the constant CAPACITY.
REQ-014 busy  output  1  SHALL be high in any state other than IDLE.
REQ-015 done  output  1  SHALL pulse for one cycle on completion.
REQ-016 error  output  1  SHALL be a sticky grant-timeout flag.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, REQ, SEND and DONE, all registered.
REQ-018 IDLE: when send=1, the block SHALL snapshot i_data into an internal shift register, clear error, zero the byte counter and timeout counter, and go to REQ next cycle.
REQ-019 IDLE: send SHALL be ignored while busy=1, including in DONE, with no queuing.
REQ-020 REQ: tx_req SHALL be 1 and the timeout counter SHALL increment every cycle.
REQ-021 REQ: on tx_ready=1 the block SHALL go to SEND.
REQ-022 REQ: when TIMEOUT!=0 and the counter reaches TIMEOUT-1 with tx_ready=0, the block SHALL set error=1, go to IDLE and not pulse done.
REQ-023 REQ: tx_ready SHALL take priority over timeout in the same cycle.
REQ-024 SEND: o_valid SHALL be 1, o_data SHALL be byte[counter], and o_last SHALL be 1 when counter==CAPACITY-1.
REQ-025 SEND: a byte SHALL transfer on each cycle with o_valid=1 and tx_data_req=1, and the counter SHALL increment only then.
REQ-026 SEND: tx_data_req=0 SHALL hold o_data and o_last stable for as long as it stays 0.
REQ-027 SEND: the transfer with o_last=1 SHALL move the FSM to DONE, and the block SHALL transfer exactly CAPACITY bytes with no gaps other than those caused by tx_data_req.
REQ-028 DONE: done SHALL be 1 for one cycle, then the FSM SHALL go to IDLE.
REQ-029 Outside SEND, o_valid, o_last and o_data SHALL be 0.
REQ-030 tx_req SHALL be 0 outside REQ.
REQ-031 The byte counter width SHALL be $clog2(CAPACITY)+1 so that CAPACITY=1 is legal; with CAPACITY=1, o_last SHALL be 1 on the first byte.
REQ-032 Changes on i_data after the snapshot SHALL not affect the packet in flight.
REQ-033 Latency SHALL be: send at cycle t, then tx_req=1 from t+1, then the first o_valid one cycle after tx_ready is sampled high.
REQ-034 tx_ready or tx_data_req asserted in IDLE or DONE SHALL have no effect.

Reset
REQ-035 During rstn=0, the block SHALL hold the FSM in IDLE, zero all counters and the shift register, and hold tx_req, o_valid, o_data, o_last, busy, done and error at 0.
REQ-036 o_len SHALL be CAPACITY during and after reset.
REQ-037 rstn asserted mid-SEND SHALL abort the packet immediately, with no done and no error.
REQ-038 After rstn deasserts, the first send SHALL behave per REQ-018.

Verification
REQ-039 CAPACITY=4, i_data=32'hDEADBEEF, send; tx_ready 3 cycles later; tx_data_req held high -> o_data DE,AD,BE,EF on consecutive cycles, o_last with EF, done 1 cycle after, busy low next.
REQ-040 CAPACITY=4, tx_data_req toggling 1,0,0,1,... -> each byte is held while ready=0, no byte is duplicated or skipped, exactly 4 transfers occur.
REQ-041 TIMEOUT=8, tx_ready never asserted -> tx_req high for 8 cycles, then error=1, busy=0, no done; a following send clears error.
REQ-042 A send pulse while busy, plus i_data changed mid-packet -> the second send is ignored and the transmitted bytes equal the original snapshot.
REQ-043 CAPACITY=1, i_data=8'h5A -> a single transfer with o_data=5A and o_last=1, then done.
REQ-044 rstn pulsed low after 2 of 4 bytes -> all outputs 0 immediately, no done, and a new send transmits the full 4 bytes from byte 0.

Source files
------------

// File: rtl/udp_writer.sv
// Single-packet payload writer for a UDP stack: snapshots a CAPACITY-byte word,
// requests a transmit slot, then streams the bytes MSB-first on the stack's per-byte ready.
module udp_writer #(
  parameter int          CAPACITY = 1,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  send,
  input  logic [CAPACITY*8-1:0] i_data,
  output logic                  tx_req,
  input  logic                  tx_ready,
  input  logic                  tx_data_req,
  output logic                  o_valid,
  output logic [7:0]            o_data,
  output logic                  o_last,
  output logic [15:0]           o_len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            dbg_state
);

  localparam int W  = CAPACITY * 8;
  localparam int CW = $clog2(CAPACITY) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    tmo_q, tmo_d;
  logic           error_q, error_d;
  logic           last_byte;
  logic           tmo_hit;

  assign last_byte = (cnt_q == CW'(CAPACITY - 1));
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TIMEOUT - 1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
    end
  end

  // Grant wins over timeout when both land on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (send) state_d = S_REQ;
      S_REQ: begin
        if (tx_ready)     state_d = S_SEND;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_SEND: if (tx_data_req && last_byte) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte handshake: a byte moves on every cycle where o_valid and tx_data_req
  // are both high; while tx_data_req is low the current byte is held unchanged.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (send) begin
          shift_d = i_data;
          cnt_d   = '0;
          tmo_d   = '0;
          error_d = 1'b0;
        end
      end
      S_REQ: begin
        tmo_d = tmo_q + 32'd1;
        if (!tx_ready && tmo_hit) error_d = 1'b1;
      end
      S_SEND: begin
        if (tx_data_req) begin
          shift_d = shift_q << 8;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    tx_req    = (state_q == S_REQ);
    o_valid   = (state_q == S_SEND);
    o_data    = (state_q == S_SEND) ? shift_q[W-1 -: 8] : 8'h00;
    o_last    = (state_q == S_SEND) && last_byte;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    error     = error_q;
    dbg_state = state_q;
  end

  assign o_len = 16'(CAPACITY);

endmodule

// File: tb/tb_udp_writer.sv
// Bench for udp_writer: a 4-byte instance (TIMEOUT=8) and a 1-byte instance,
// scored against a byte queue built from each snapshot.
module tb_udp_writer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp_q[$];

  logic        a_send = 0, a_tx_ready = 0, a_tx_data_req = 0;
  logic [31:0] a_i_data = '0;
  logic        a_tx_req, a_o_valid, a_o_last, a_busy, a_done, a_error;
  logic [7:0]  a_o_data;
  logic [15:0] a_o_len;
  logic [1:0]  a_dbg;

  logic        b_send = 0, b_tx_ready = 0, b_tx_data_req = 0;
  logic [7:0]  b_i_data = '0;
  logic        b_tx_req, b_o_valid, b_o_last, b_busy, b_done, b_error;
  logic [7:0]  b_o_data;
  logic [15:0] b_o_len;
  logic [1:0]  b_dbg;

  udp_writer #(.CAPACITY(4), .TIMEOUT(8)) dut_a (
    .clk(clk), .rstn(rstn), .send(a_send), .i_data(a_i_data),
    .tx_req(a_tx_req), .tx_ready(a_tx_ready), .tx_data_req(a_tx_data_req),
    .o_valid(a_o_valid), .o_data(a_o_data), .o_last(a_o_last), .o_len(a_o_len),
    .busy(a_busy), .done(a_done), .error(a_error), .dbg_state(a_dbg)
  );

  udp_writer #(.CAPACITY(1), .TIMEOUT(8)) dut_b (
    .clk(clk), .rstn(rstn), .send(b_send), .i_data(b_i_data),
    .tx_req(b_tx_req), .tx_ready(b_tx_ready), .tx_data_req(b_tx_data_req),
    .o_valid(b_o_valid), .o_data(b_o_data), .o_last(b_o_last), .o_len(b_o_len),
    .busy(b_busy), .done(b_done), .error(b_error), .dbg_state(b_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (a_state=%0d b_state=%0d)",
             tag, obs, exp, a_dbg, b_dbg);
    end
  endtask

  // Driver: one packet on the 4-byte instance. mode 0 = data ready always high,
  // 1 = pattern 1,0,0 repeating, 2 = random. disturb pokes send/i_data mid-packet.
  task automatic run_pkt4(input logic [31:0] data, input int rdy_delay,
                          input int mode, input bit disturb);
    int  n;
    bit  dreq;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(data >> (8 * (3 - k))));
    a_i_data = data;
    a_send   = 1'b1;
    tick();
    a_send   = 1'b0;
    chk("req_tx_req", a_tx_req, 1);
    chk("req_busy", a_busy, 1);
    chk("req_error_cleared", a_error, 0);
    chk("req_no_valid", a_o_valid, 0);
    for (int i = 0; i < rdy_delay; i++) begin
      if (disturb) a_i_data = $urandom;
      tick();
      chk("req_wait_tx_req", a_tx_req, 1);
    end
    a_tx_ready = 1'b1;
    tick();
    a_tx_ready = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      chk("send_valid", a_o_valid, 1);
      chk("send_data", a_o_data, exp_q[0]);
      chk("send_last", a_o_last, (exp_q.size() == 1) ? 1 : 0);
      chk("send_tx_req_low", a_tx_req, 0);
      case (mode)
        0: dreq = 1'b1;
        1: dreq = (n % 3 == 0);
        default: dreq = 1'($urandom_range(0, 1));
      endcase
      if (disturb) begin
        a_i_data = $urandom;
        a_send   = 1'($urandom_range(0, 1));
      end
      a_tx_data_req = dreq;
      tick();
      if (dreq) void'(exp_q.pop_front());
      n++;
    end
    a_send = 1'b0;
    a_tx_data_req = 1'b0;
    chk("xfer_count_left", exp_q.size(), 0);
    chk("done_pulse", a_done, 1);
    chk("done_busy", a_busy, 1);
    chk("done_no_valid", a_o_valid, 0);
    if (disturb) begin
      a_send = 1'b1;
      a_tx_ready = 1'b1;
    end
    tick();
    a_send = 1'b0;
    a_tx_ready = 1'b0;
    chk("post_done_low", a_done, 0);
    chk("post_busy_low", a_busy, 0);
    chk("post_tx_req_low", a_tx_req, 0);
    chk("post_error_low", a_error, 0);
  endtask

  initial begin
    rstn = 1'b0;
    tick();
    chk("rst_busy", a_busy, 0);
    chk("rst_tx_req", a_tx_req, 0);
    chk("rst_valid", a_o_valid, 0);
    chk("rst_data", a_o_data, 0);
    chk("rst_done", a_done, 0);
    chk("rst_error", a_error, 0);
    chk("rst_len_a", a_o_len, 4);
    chk("rst_len_b", b_o_len, 1);
    rstn = 1'b1;
    tick();

    // Basic packet, grant 3 cycles after send, data ready always high
    run_pkt4(32'hDEADBEEF, 2, 0, 0);
    // Stalled byte handshake
    run_pkt4(32'h01234567, 0, 1, 0);
    // Ignored send pulses and changing i_data while busy
    run_pkt4(32'hCAFEF00D, 3, 0, 1);
    // Grant on the very last timeout cycle must still win
    run_pkt4(32'hA5C3E187, 7, 2, 0);

    // Grants and data-ready while idle do nothing
    a_tx_ready = 1'b1;
    a_tx_data_req = 1'b1;
    tick();
    tick();
    chk("idle_ignore_busy", a_busy, 0);
    chk("idle_ignore_valid", a_o_valid, 0);
    chk("idle_ignore_tx_req", a_tx_req, 0);
    a_tx_ready = 1'b0;
    a_tx_data_req = 1'b0;

    // Grant timeout
    a_i_data = 32'h11223344;
    a_send = 1'b1;
    tick();
    a_send = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("tmo_tx_req_high", a_tx_req, 1);
      chk("tmo_error_low", a_error, 0);
      tick();
    end
    chk("tmo_error_set", a_error, 1);
    chk("tmo_busy_low", a_busy, 0);
    chk("tmo_no_done", a_done, 0);
    chk("tmo_tx_req_low", a_tx_req, 0);
    tick();
    chk("tmo_error_sticky", a_error, 1);
    run_pkt4(32'h55AA33CC, 1, 0, 0);

    // Reset in the middle of a packet
    a_i_data = 32'hDEADBEEF;
    a_send = 1'b1;
    tick();
    a_send = 1'b0;
    a_tx_ready = 1'b1;
    tick();
    a_tx_ready = 1'b0;
    a_tx_data_req = 1'b1;
    tick();
    tick();
    chk("mid_valid", a_o_valid, 1);
    chk("mid_data_byte2", a_o_data, 8'hBE);
    rstn = 1'b0;
    #1;
    chk("abort_valid", a_o_valid, 0);
    chk("abort_data", a_o_data, 0);
    chk("abort_busy", a_busy, 0);
    chk("abort_done", a_done, 0);
    chk("abort_error", a_error, 0);
    chk("abort_len", a_o_len, 4);
    a_tx_data_req = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    chk("abort_still_no_done", a_done, 0);
    tick();
    run_pkt4(32'hDEADBEEF, 0, 0, 0);

    // Randomized packets
    for (int p = 0; p < 8; p++)
      run_pkt4($urandom, $urandom_range(0, 7), 2, p[0]);

    // Single-byte instance
    b_i_data = 8'h5A;
    b_send = 1'b1;
    tick();
    b_send = 1'b0;
    b_i_data = 8'h00;
    chk("b_tx_req", b_tx_req, 1);
    b_tx_ready = 1'b1;
    tick();
    b_tx_ready = 1'b0;
    chk("b_valid", b_o_valid, 1);
    chk("b_data", b_o_data, 8'h5A);
    chk("b_last", b_o_last, 1);
    b_tx_data_req = 1'b1;
    tick();
    b_tx_data_req = 1'b0;
    chk("b_done", b_done, 1);
    chk("b_valid_low", b_o_valid, 0);
    tick();
    chk("b_busy_low", b_busy, 0);
    chk("b_error_low", b_error, 0);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
